regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Shares the single write port of the 32×64 register file between two writeback sources: the ALU pipe and the memory/load pipe. Arbitration is round-robin, with a registered drive of the port. The block also keeps a busy-bit scoreboard of in-flight destination registers, so issue logic can stall on RAW and WAW hazards. It sits between the execute/memory stages and the register file's RegWrite/WriteRegister/WriteData inputs.

## Interface
Parameters:
- DATA_W, 64, register data width
- NREG, 32, number of architectural registers
- ADDR_W, 5, register index width

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset_n  in  1  reset, synchronous and active-low
- alu_valid / alu_ready  in / out  1  ALU writeback handshake
- alu_addr  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- mem_valid / mem_ready  in / out  1  memory writeback handshake
- mem_addr  in  ADDR_W  memory destination register
- mem_data  in  DATA_W  load data
- RegWrite  out  1  register file write enable (registered)
- WriteRegister  out  ADDR_W  register file write index (registered)
- WriteData  out  DATA_W  register file write data (registered)
- issue_valid / issue_ready  in / out  1  issue-side destination reservation
- issue_addr  in  ADDR_W  destination being reserved
- rd1_addr, rd2_addr  in  ADDR_W  source operands to check
- rd1_busy, rd2_busy  out  1  combinational busy lookup
- busy_mask  out  NREG  full scoreboard
- pending_cnt  out  ADDR_W+1  number of busy registers

## Operation
- Register 31 (XZR) is hardwired.
  - It is never marked busy.
  - A writeback to it is accepted and consumed, but RegWrite stays 0.
- Arbiter FSM has two states, PRI_ALU and PRI_MEM. Reset state is PRI_ALU.
- Grant rules:
  - Only one source valid: that source is granted.
  - Both sources valid: the priority source is granted, and the FSM moves to the other state.
  - Single-source grant: the FSM moves to the state favouring the other source.
  - No grant: state holds.
- Ready outputs:
  - alu_ready and mem_ready are combinational and equal the grant.
  - A transfer occurs on valid&&ready at the clock edge.
  - Requesters hold valid, addr and data stable until ready.
- Output register behaviour:
  - Each transfer loads WriteRegister and WriteData from the winning source.
  - RegWrite is loaded as (addr != XZR).
  - A cycle with no transfer loads RegWrite=0; WriteRegister and WriteData hold.
- Scoreboard:
  - An issue transfer (issue_valid&&issue_ready) sets busy[issue_addr].
  - RegWrite=1 clears busy[WriteRegister] on the same edge the register file commits.
- issue_ready = !busy[issue_addr] || issue_addr==XZR. There is no bypass of a same-cycle clear (WAW stall).
- Simultaneous set and clear of the same index: set wins, and busy stays 1.
- rd*_busy = busy[rd*_addr]. It always reads 0 for XZR.
- pending_cnt = popcount(busy_mask). Range is 0..31.
- Writeback to a non-busy register is legal: the register file is written and the scoreboard is unchanged.
- Reset (reset_n=0 at edge):
  - busy_mask=0 and pending_cnt=0.
  - RegWrite=0, WriteRegister=0, WriteData=0.
  - FSM=PRI_ALU.
  - alu_ready, mem_ready and issue_ready are forced 0 while reset_n=0.
  - An in-flight writeback is dropped. An in-flight RegWrite pulse is cancelled.

## Timing
- Handshake to register file write: 1 cycle. A transfer at edge N gives RegWrite=1 during cycle N+1, committed at edge N+1.
- Busy clear occurs at edge N+1, so a reader sees busy=1 through cycle N+1 and 0 from cycle N+2.
- Issue set at edge N: busy visible from cycle N+1.
- Throughput is one writeback per cycle total. Under continuous dual contention each source gets every other cycle.
- All outputs except ready/busy lookups are registered.

## Structure
- Package regfile_pkg holds:
  - DATA_W, NREG and ADDR_W defaults
  - localparam XZR = 5'd31
  - typedef enum logic {PRI_ALU, PRI_MEM} wb_pri_e
  - typedef struct {addr, data} wb_req_t
- One sub-module, wb_scoreboard, holds the busy flops, set/clear priority, lookups and popcount.
- The arbiter FSM and output register live in the top.

## Test plan
1. Reset: hold reset_n=0 for 2 cycles with all valids high.
   - Required: readies 0, RegWrite 0, busy_mask 0, pending_cnt 0.
2. Single source: alu_valid with addr=5, data=64'hDEAD_BEEF.
   - Required: alu_ready same cycle.
   - Next cycle: RegWrite=1, WriteRegister=5, WriteData=DEAD_BEEF.
3. Contention: both valid for 4 cycles, ALU addr 1..4 and MEM addr 11..14.
   - Required: grants alternate ALU, MEM, ALU, MEM.
   - RegWrite indices 1, 11, 2, 12 follow.
4. Scoreboard: issue addr=7, then mem writeback to 7.
   - Required: busy[7] set the cycle after issue, pending_cnt=1.
   - rd1_busy with rd1_addr=7 stays 1 through the RegWrite cycle and is 0 afterward.
   - issue of 7 is blocked while busy.
5. Simultaneous events: issue addr=9 on the same edge that RegWrite clears 9.
   - Required: busy[9] remains 1.
6. XZR and mid-operation reset:
   - Writeback to 31: accepted, RegWrite=0.
   - Issue to 31: ready, no busy set.
   - Assert reset_n=0 during a RegWrite cycle: busy_mask→0 and RegWrite→0 the next cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback arbiter and its scoreboard.
package regfile_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int NREG_DEF   = 32;
  localparam int ADDR_W_DEF = 5;

  // Zero register: reads as zero, never reserved, writes are swallowed.
  localparam logic [ADDR_W_DEF-1:0] XZR = 5'd31;

  typedef enum logic {PRI_ALU, PRI_MEM} wb_pri_e;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Busy-bit scoreboard of in-flight destination registers, with combinational
// lookups and a registered count of outstanding reservations.
module wb_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG   = NREG_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              setEn,
  input  logic [ADDR_W-1:0] setAddr,
  input  logic              clrEn,
  input  logic [ADDR_W-1:0] clrAddr,
  input  logic [ADDR_W-1:0] issueAddr,
  input  logic [ADDR_W-1:0] rd1Addr,
  input  logic [ADDR_W-1:0] rd2Addr,
  output logic              issueBusy,
  output logic              rd1Busy,
  output logic              rd2Busy,
  output logic [NREG-1:0]   busyMask,
  output logic [ADDR_W:0]   pendingCnt
);

  logic [NREG-1:0] busyNext;
  logic [ADDR_W:0] cntNext;

  // A reservation landing on the same edge as the retiring write must survive.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : gBusy
      localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
      assign busyNext[gi] = (IDX != XZR) &&
                            ((setEn && setAddr == IDX) ||
                             (busyMask[gi] && !(clrEn && clrAddr == IDX)));
    end
  endgenerate

  always_comb begin
    cntNext = '0;
    for (int i = 0; i < NREG; i++) begin
      cntNext = cntNext + {{ADDR_W{1'b0}}, busyNext[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busyMask   <= '0;
      pendingCnt <= '0;
    end else begin
      busyMask   <= busyNext;
      pendingCnt <= cntNext;
    end
  end

  assign issueBusy = busyMask[issueAddr];
  assign rd1Busy   = busyMask[rd1Addr];
  assign rd2Busy   = busyMask[rd2Addr];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin sharing of the register-file write port between the ALU and
// memory writeback pipes, plus the hazard scoreboard for issue.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic [ADDR_W-1:0] rd1_addr,
  input  logic [ADDR_W-1:0] rd2_addr,
  output logic              rd1_busy,
  output logic              rd2_busy,
  output logic [NREG-1:0]   busy_mask,
  output logic [ADDR_W:0]   pending_cnt
);

  wb_pri_e stateReg, stateNext;
  logic    grantAlu, grantMem;
  wb_req_t winReq;
  logic    issueBusy;

  always_ff @(posedge clk) begin
    if (!reset_n) stateReg <= PRI_ALU;
    else          stateReg <= stateNext;
  end

  // Any grant hands priority to the other source, so a lone requester
  // cannot starve the other once it starts asking.
  always_comb begin
    stateNext = stateReg;
    grantAlu  = 1'b0;
    grantMem  = 1'b0;
    winReq    = '{addr: alu_addr, data: alu_data};
    if (reset_n) begin
      if (alu_valid && (!mem_valid || stateReg == PRI_ALU)) begin
        grantAlu  = 1'b1;
        stateNext = PRI_MEM;
      end else if (mem_valid) begin
        grantMem  = 1'b1;
        stateNext = PRI_ALU;
        winReq    = '{addr: mem_addr, data: mem_data};
      end
    end
  end

  assign alu_ready = grantAlu;
  assign mem_ready = grantMem;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else if (grantAlu || grantMem) begin
      RegWrite      <= (winReq.addr != XZR);
      WriteRegister <= winReq.addr;
      WriteData     <= winReq.data;
    end else begin
      RegWrite      <= 1'b0;
    end
  end

  // No bypass of a retiring write: a WAW re-issue waits one extra cycle.
  assign issue_ready = reset_n && (!issueBusy || issue_addr == XZR);

  wb_scoreboard #(.NREG(NREG), .ADDR_W(ADDR_W)) uScoreboard (
    .clk        (clk),
    .reset_n    (reset_n),
    .setEn      (issue_valid && issue_ready),
    .setAddr    (issue_addr),
    .clrEn      (RegWrite),
    .clrAddr    (WriteRegister),
    .issueAddr  (issue_addr),
    .rd1Addr    (rd1_addr),
    .rd2Addr    (rd2_addr),
    .issueBusy  (issueBusy),
    .rd1Busy    (rd1_busy),
    .rd2Busy    (rd2_busy),
    .busyMask   (busy_mask),
    .pendingCnt (pending_cnt)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed plus randomized checks of the writeback arbiter against a
// behavioural model of grants, register-file writes and the busy set.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        alu_valid, alu_ready, mem_valid, mem_ready;
  logic [4:0]  alu_addr, mem_addr;
  logic [63:0] alu_data, mem_data;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic        issue_valid, issue_ready;
  logic [4:0]  issue_addr, rd1_addr, rd2_addr;
  logic        rd1_busy, rd2_busy;
  logic [31:0] busy_mask;
  logic [5:0]  pending_cnt;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_addr(issue_addr),
    .rd1_addr(rd1_addr), .rd2_addr(rd2_addr), .rd1_busy(rd1_busy), .rd2_busy(rd2_busy),
    .busy_mask(busy_mask), .pending_cnt(pending_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: set of reserved registers, pending register-file write,
  // and which source was served most recently (the other one wins a tie).
  bit [31:0]   mBusy = '0;
  bit          mRegWrite = 1'b0;
  logic [4:0]  mWReg = '0;
  logic [63:0] mWData = '0;
  bit          memServedLast = 1'b1;
  bit          gAlu, gMem;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit          eA, eM, iFire;
    bit [31:0]   nb;
    bit          nRW, nLast;
    logic [4:0]  nWR;
    logic [63:0] nWD;
    #1;
    eA = reset_n && alu_valid && (!mem_valid || memServedLast);
    eM = reset_n && mem_valid && (!alu_valid || !memServedLast);
    iFire = reset_n && issue_valid && (!mBusy[issue_addr] || issue_addr == 5'd31);
    chk("alu_ready", alu_ready, eA);
    chk("mem_ready", mem_ready, eM);
    chk("issue_ready", issue_ready, reset_n && (!mBusy[issue_addr] || issue_addr == 5'd31));
    chk("rd1_busy", rd1_busy, mBusy[rd1_addr]);
    chk("rd2_busy", rd2_busy, mBusy[rd2_addr]);
    gAlu = eA;
    gMem = eM;
    nb = mBusy; nRW = 1'b0; nWR = mWReg; nWD = mWData; nLast = memServedLast;
    if (!reset_n) begin
      nb = '0; nWR = '0; nWD = '0; nLast = 1'b1;
    end else begin
      if (mRegWrite) nb[mWReg] = 1'b0;
      if (iFire && issue_addr != 5'd31) nb[issue_addr] = 1'b1;
      if (eA) begin
        nRW = (alu_addr != 5'd31); nWR = alu_addr; nWD = alu_data; nLast = 1'b0;
        $display("wb alu addr=%0d data=%h", alu_addr, alu_data);
      end else if (eM) begin
        nRW = (mem_addr != 5'd31); nWR = mem_addr; nWD = mem_data; nLast = 1'b1;
        $display("wb mem addr=%0d data=%h", mem_addr, mem_data);
      end
    end
    @(posedge clk);
    #1;
    mBusy = nb; mRegWrite = nRW; mWReg = nWR; mWData = nWD; memServedLast = nLast;
    chk("RegWrite", RegWrite, mRegWrite);
    chk("WriteRegister", WriteRegister, mWReg);
    chk("WriteData", WriteData, mWData);
    chk("busy_mask", busy_mask, mBusy);
    chk("pending_cnt", pending_cnt, $countones(mBusy));
  endtask

  initial begin
    logic [4:0] seq [4];
    seq[0] = 5'd1; seq[1] = 5'd11; seq[2] = 5'd2; seq[3] = 5'd12;

    // Reset with every requester asserting.
    reset_n = 1'b0;
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 64'h1111;
    mem_valid = 1'b1; mem_addr = 5'd4; mem_data = 64'h2222;
    issue_valid = 1'b1; issue_addr = 5'd6; rd1_addr = 5'd6; rd2_addr = 5'd0;
    @(posedge clk);
    #1;
    repeat (2) cycle();
    chk("t1 alu_ready", alu_ready, 1'b0);
    chk("t1 mem_ready", mem_ready, 1'b0);
    chk("t1 issue_ready", issue_ready, 1'b0);
    chk("t1 RegWrite", RegWrite, 1'b0);
    chk("t1 busy_mask", busy_mask, 32'd0);
    chk("t1 pending_cnt", pending_cnt, 6'd0);
    reset_n = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0; issue_valid = 1'b0;

    // Single ALU writeback.
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 64'hDEAD_BEEF;
    #1 chk("t2 alu_ready", alu_ready, 1'b1);
    cycle();
    alu_valid = 1'b0;
    chk("t2 RegWrite", RegWrite, 1'b1);
    chk("t2 WriteRegister", WriteRegister, 5'd5);
    chk("t2 WriteData", WriteData, 64'hDEAD_BEEF);

    // Single MEM writeback hands priority back to the ALU.
    mem_valid = 1'b1; mem_addr = 5'd20; mem_data = 64'h0BAD_F00D;
    cycle();
    mem_valid = 1'b0;
    chk("t2m WriteRegister", WriteRegister, 5'd20);

    // Dual contention alternates.
    alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 64'hA1;
    mem_valid = 1'b1; mem_addr = 5'd11; mem_data = 64'hB11;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("t3 alu granted", gAlu, (k % 2) == 0);
      chk("t3 WriteRegister", WriteRegister, seq[k]);
      if (gAlu) begin alu_addr = alu_addr + 5'd1; alu_data = alu_data + 64'd1; end
      if (gMem) begin mem_addr = mem_addr + 5'd1; mem_data = mem_data + 64'd1; end
    end
    alu_valid = 1'b0; mem_valid = 1'b0;

    // Reservation of 7 and its retirement via the memory pipe.
    issue_valid = 1'b1; issue_addr = 5'd7; rd1_addr = 5'd7;
    cycle();
    chk("t4 busy7 set", busy_mask[7], 1'b1);
    chk("t4 pending", pending_cnt, 6'd1);
    chk("t4 rd1_busy", rd1_busy, 1'b1);
    #1 chk("t4 issue blocked", issue_ready, 1'b0);
    cycle();
    issue_valid = 1'b0;
    mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 64'h7777;
    cycle();
    mem_valid = 1'b0;
    chk("t4 RegWrite", RegWrite, 1'b1);
    chk("t4 rd1_busy in RegWrite cycle", rd1_busy, 1'b1);
    chk("t4 issue blocked in RegWrite cycle", issue_ready, 1'b0);
    cycle();
    chk("t4 rd1_busy after", rd1_busy, 1'b0);
    chk("t4 pending after", pending_cnt, 6'd0);

    // Set and clear of 9 on the same edge: set wins.
    mem_valid = 1'b1; mem_addr = 5'd9; mem_data = 64'h9999;
    cycle();
    mem_valid = 1'b0;
    issue_valid = 1'b1; issue_addr = 5'd9;
    cycle();
    issue_valid = 1'b0;
    chk("t5 busy9 kept", busy_mask[9], 1'b1);
    alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 64'h9A9A;
    cycle();
    alu_valid = 1'b0;
    cycle();
    chk("t5 busy9 cleared", busy_mask[9], 1'b0);

    // XZR writeback and reservation.
    alu_valid = 1'b1; alu_addr = 5'd31; alu_data = 64'h3131;
    #1 chk("t6 xzr alu_ready", alu_ready, 1'b1);
    cycle();
    alu_valid = 1'b0;
    chk("t6 xzr RegWrite", RegWrite, 1'b0);
    chk("t6 xzr WriteRegister", WriteRegister, 5'd31);
    issue_valid = 1'b1; issue_addr = 5'd31;
    #1 chk("t6 xzr issue_ready", issue_ready, 1'b1);
    cycle();
    chk("t6 xzr not busy", busy_mask[31], 1'b0);
    chk("t6 xzr pending", pending_cnt, 6'd0);

    // Reset during a RegWrite cycle with reservations outstanding.
    issue_addr = 5'd3;
    cycle();
    issue_addr = 5'd4;
    mem_valid = 1'b1; mem_addr = 5'd3; mem_data = 64'h3333;
    cycle();
    issue_valid = 1'b0; mem_valid = 1'b0;
    chk("t6 RegWrite before reset", RegWrite, 1'b1);
    reset_n = 1'b0; alu_valid = 1'b1; alu_addr = 5'd8; alu_data = 64'h8888;
    #1 chk("t6 alu_ready in reset", alu_ready, 1'b0);
    cycle();
    chk("t6 RegWrite after reset", RegWrite, 1'b0);
    chk("t6 busy_mask after reset", busy_mask, 32'd0);
    reset_n = 1'b1; alu_valid = 1'b0;

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      if (!alu_valid && $urandom_range(0, 2) != 0) begin
        alu_valid = 1'b1; alu_addr = 5'($urandom_range(0, 31)); alu_data = {$urandom, $urandom};
      end
      if (!mem_valid && $urandom_range(0, 2) != 0) begin
        mem_valid = 1'b1; mem_addr = 5'($urandom_range(0, 31)); mem_data = {$urandom, $urandom};
      end
      issue_valid = 1'($urandom_range(0, 1));
      issue_addr = 5'($urandom_range(0, 31));
      rd1_addr = 5'($urandom_range(0, 31));
      rd2_addr = 5'($urandom_range(0, 31));
      reset_n = ($urandom_range(0, 99) != 0);
      cycle();
      if (gAlu) alu_valid = 1'b0;
      if (gMem) mem_valid = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
